rr_arbiter_8: RTL

Round-robin arbiter that shares one resource between eight requesters and issues a registered one-hot grant. Internally it selects a 3-bit winner index and decodes it to the one-hot `gnt` bus. A grant is held while its requester keeps `req` high, up to a configurable hold limit. The block sits in front of any 8-way shared datapath resource, such as a bus, memory port or functional unit, whose users are enumerated 0..7.

---
 rtl/arb_pkg.sv | 12 +
 rtl/decoder_3_to_8.sv | 11 +
 rtl/rr_pick8.sv | 25 ++
 rtl/rr_arbiter_8.sv | 105 ++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

endpackage

// File: rtl/decoder_3_to_8.sv
// Binary-to-one-hot decoder shared across the codebase.
module decoder_3_to_8 (
    input  logic [2:0] a,
    output logic [7:0] y
);

    always_comb begin
        y = 8'b1 << a;
    end

endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set bit of cand scanning ptr, ptr+1, ... modulo 8.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] cand,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    always_comb begin
        // Rotate so ptr lands at bit 0; the lowest set bit of rot is then the winner offset.
        rot = N_REQ'({cand, cand} >> ptr);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        found = |cand;
        idx   = ptr + off;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters with a registered grant index and a
// per-grant hold limit that forces release only when someone else is waiting.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy
);

    localparam bit       HOLD_EN   = (MAX_HOLD != 0);
    localparam bit [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_e           st_q, st_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

    logic [N_REQ-1:0] cur_dec;
    logic [N_REQ-1:0] pick_cand;
    logic [IDX_W-1:0] pick_ptr;
    logic [IDX_W-1:0] next_ptr;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    decoder_3_to_8 u_dec (
        .a (gnt_idx_q),
        .y (cur_dec)
    );

    // While granted, the holder is masked out and the scan starts just past it;
    // on a release its req bit is already low, so the mask is harmless there.
    assign next_ptr  = gnt_idx_q + IDX_W'(1);
    assign pick_cand = (st_q == GRANT) ? (req & ~cur_dec) : req;
    assign pick_ptr  = (st_q == GRANT) ? next_ptr : ptr_q;

    rr_pick8 u_pick (
        .cand  (pick_cand),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        st_d       = st_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_idx_d  = gnt_idx_q;

        case (st_q)
            IDLE: begin
                if (pick_found) begin
                    st_d       = GRANT;
                    gnt_idx_d  = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_idx_q]) begin
                    ptr_d      = next_ptr;
                    hold_cnt_d = '0;
                    if (pick_found) gnt_idx_d = pick_idx;
                    else            st_d      = IDLE;
                end else if (HOLD_EN && hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    if (pick_found) begin
                        ptr_d     = next_ptr;
                        gnt_idx_d = pick_idx;
                    end
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_idx_q  <= '0;
        end else begin
            st_q       <= st_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_idx_q  <= gnt_idx_d;
        end
    end

    assign gnt_valid = (st_q == GRANT);
    assign busy      = gnt_valid;
    assign gnt_idx   = gnt_idx_q;
    assign gnt       = gnt_valid ? cur_dec : '0;

endmodule
